// File: rtl/sdram_traffic_chk_if.sv
// User-side FIFO bus between the traffic checker and sdram_top.
// master = traffic checker, slave = FIFO/controller side.
interface sdram_traffic_chk_if #(
    parameter int DATA_W = 16,
    parameter int NUM_W  = 10
);
    logic              wr_fifo_wr_req;
    logic [DATA_W-1:0] wr_fifo_wr_data;
    logic              rd_fifo_rd_req;
    logic [DATA_W-1:0] rd_fifo_rd_data;
    logic [NUM_W-1:0]  rd_fifo_num;
    logic              rd_valid;

    modport master (
        output wr_fifo_wr_req, wr_fifo_wr_data, rd_fifo_rd_req, rd_valid,
        input  rd_fifo_rd_data, rd_fifo_num
    );

    modport slave (
        input  wr_fifo_wr_req, wr_fifo_wr_data, rd_fifo_rd_req, rd_valid,
        output rd_fifo_rd_data, rd_fifo_num
    );
endinterface

// File: rtl/sdram_traffic_chk.sv
// Write/read-back traffic generator and checker for the sdram_top user FIFOs.
// Writes NUM_WORDS patterned words, waits for the read FIFO, reads back and compares.
module sdram_traffic_chk #(
    parameter int                NUM_W     = 10,
    parameter int                DATA_W    = 16,
    parameter int                NUM_WORDS = 10,
    parameter int                WR_GAP    = 7,
    parameter int                TIMEOUT   = 65535,
    parameter logic [DATA_W-1:0] SEED      = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    sdram_traffic_chk_if.master  fifo,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [NUM_W-1:0]     err_cnt,
    output logic [NUM_W-1:0]     first_err_idx
);

    localparam int GAP_W = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(WR_GAP);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [NUM_W-1:0]  IDX_LAST = NUM_W'(NUM_WORDS - 1);
    localparam logic [NUM_W-1:0]  NUM_TGT  = NUM_W'(NUM_WORDS);
    localparam logic [DATA_W-1:0] CHK_A    = DATA_W'({(DATA_W + 1) / 2{2'b01}});

    // Fibonacci taps as a mask over bits (W - tap); feedback enters at the MSB.
    function automatic logic [63:0] lfsr_taps(input int w);
        case (w)
            8:       return 64'h0000_0000_0000_001D;
            16:      return 64'h0000_0000_0000_002D;
            32:      return 64'h0000_0000_C000_0401;
            default: return 64'h0000_0000_0000_0003;
        endcase
    endfunction

    localparam logic [DATA_W-1:0] LFSR_MASK = DATA_W'(lfsr_taps(DATA_W));

    function automatic logic [DATA_W-1:0] gen_seed(input logic [1:0] m);
        case (m)
            2'd1:    return SEED;
            2'd3:    return CHK_A;
            default: return DATA_W'(1);
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] gen_next(input logic [1:0] m, input logic [DATA_W-1:0] g);
        case (m)
            2'd0:    return g + DATA_W'(1);
            2'd1:    return {^(g & LFSR_MASK), g[DATA_W-1:1]};
            2'd2:    return {g[DATA_W-2:0], g[DATA_W-1]};
            default: return ~g;
        endcase
    endfunction

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WAIT_RD, S_READ, S_CHECK_LAST, S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] gen;
    logic [NUM_W-1:0]  idx;
    logic [GAP_W-1:0]  gap;
    logic [TMR_W-1:0]  tmr;
    logic [DATA_W-1:0] exp_d;
    logic [NUM_W-1:0]  idx_d;
    logic              req_d;
    logic              wr_fire;
    logic              fifo_ready;

    assign fifo_ready = (fifo.rd_fifo_num >= NUM_TGT);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_WRITE;
            S_WRITE:        if (wr_fire && idx == IDX_LAST) state_nx = S_WAIT_RD;
            S_WAIT_RD: begin
                if (fifo_ready)            state_nx = S_READ;
                else if (tmr == TMR_LAST)  state_nx = S_DONE;
            end
            S_READ:         if (idx == IDX_LAST) state_nx = S_CHECK_LAST;
            S_CHECK_LAST:   state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        wr_fire              = (state == S_WRITE) && (gap == GAP_LAST);
        fifo.wr_fifo_wr_req  = wr_fire;
        fifo.wr_fifo_wr_data = gen;
        fifo.rd_fifo_rd_req  = (state == S_READ);
        fifo.rd_valid        = (state == S_IDLE) || (state == S_WRITE);
        busy                 = !((state == S_IDLE) || (state == S_DONE));
        pass                 = (state == S_DONE) && (err_cnt == '0) && !timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q        <= '0;
            gen           <= '0;
            idx           <= '0;
            gap           <= '0;
            tmr           <= '0;
            exp_d         <= '0;
            idx_d         <= '0;
            req_d         <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '1;
        end else begin
            done  <= (state_nx == S_DONE) && (state != S_DONE);
            // Expected word and index trail the request by one cycle to meet the FIFO data.
            req_d <= fifo.rd_fifo_rd_req;
            exp_d <= gen;
            idx_d <= idx;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_q        <= mode;
                        gen           <= gen_seed(mode);
                        idx           <= '0;
                        gap           <= '0;
                        tmr           <= '0;
                        timeout       <= 1'b0;
                        err_cnt       <= '0;
                        first_err_idx <= '1;
                    end
                end
                S_WRITE: begin
                    if (wr_fire) begin
                        gap <= '0;
                        gen <= gen_next(mode_q, gen);
                        idx <= (idx == IDX_LAST) ? '0 : idx + NUM_W'(1);
                    end else begin
                        gap <= gap + GAP_W'(1);
                    end
                end
                S_WAIT_RD: begin
                    tmr <= tmr + TMR_W'(1);
                    if (fifo_ready)           gen     <= gen_seed(mode_q);
                    else if (tmr == TMR_LAST) timeout <= 1'b1;
                end
                S_READ: begin
                    gen <= gen_next(mode_q, gen);
                    idx <= idx + NUM_W'(1);
                end
                default: ;
            endcase
            if (req_d && (fifo.rd_fifo_rd_data != exp_d)) begin
                if (err_cnt != '1)       err_cnt       <= err_cnt + NUM_W'(1);
                if (first_err_idx == '1) first_err_idx <= idx_d;
            end
        end
    end

endmodule

// File: tb/tb_sdram_traffic_chk.sv
// Randomized scoreboard bench for sdram_traffic_chk with a behavioural FIFO/SDRAM stand-in.
// A second small instance exercises the narrow err_cnt configuration.
module tb_sdram_traffic_chk;

    localparam int          DW     = 16;
    localparam int          NW     = 10;
    localparam int          NWORDS = 10;
    localparam int          GAP    = 7;
    localparam int          TO     = 100;
    localparam logic [15:0] SEED   = 16'hACE1;

    localparam int F_NONE = 0, F_BIT0 = 1, F_ZERO = 2, F_XOR = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, start_b;
    logic [1:0]    mode;
    logic          busy, done, pass, timeout;
    logic [NW-1:0] err_cnt, first_err_idx;
    logic          busy_b, done_b, pass_b, timeout_b;
    logic [2:0]    err_b, first_b;

    sdram_traffic_chk_if #(.DATA_W(DW), .NUM_W(NW)) fif ();
    sdram_traffic_chk_if #(.DATA_W(DW), .NUM_W(3))  fif_b ();

    sdram_traffic_chk #(
        .NUM_W(NW), .DATA_W(DW), .NUM_WORDS(NWORDS), .WR_GAP(GAP), .TIMEOUT(TO), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .fifo(fif),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_cnt(err_cnt), .first_err_idx(first_err_idx)
    );

    sdram_traffic_chk #(
        .NUM_W(3), .DATA_W(DW), .NUM_WORDS(7), .WR_GAP(0), .TIMEOUT(TO), .SEED(SEED)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(2'd0), .fifo(fif_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b),
        .err_cnt(err_b), .first_err_idx(first_b)
    );

    // Narrow instance reads back stuck-at-zero data with the FIFO always full.
    assign fif_b.rd_fifo_rd_data = '0;
    assign fif_b.rd_fifo_num     = 3'd7;

    int unsigned n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
        logic b;
        b = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {b, s[DW-1:1]};
    endfunction

    function automatic logic [DW-1:0] pattern(input logic [1:0] m, input int unsigned i);
        logic [DW-1:0] s;
        case (m)
            2'd0: return DW'(i + 1);
            2'd1: begin
                s = SEED;
                repeat (i) s = lfsr_step(s);
                return s;
            end
            2'd2:    return DW'(1) << (i % DW);
            default: return (i % 2 == 0) ? 16'h5555 : 16'hAAAA;
        endcase
    endfunction

    int            fault_kind = F_NONE;
    int unsigned   fault_idx  = 0;
    logic [DW-1:0] fault_xor  = '0;

    function automatic logic [DW-1:0] apply_fault(input logic [DW-1:0] w, input int unsigned i);
        case (fault_kind)
            F_BIT0:  return (i == fault_idx) ? (w | DW'(1)) : w;
            F_ZERO:  return '0;
            F_XOR:   return (i == fault_idx) ? (w ^ fault_xor) : w;
            default: return w;
        endcase
    endfunction

    typedef struct packed {
        logic          pass;
        logic          tmo;
        logic [NW-1:0] err;
        logic [NW-1:0] first;
    } res_t;

    logic [DW-1:0] exp_wr_q[$];
    res_t          exp_res_q[$];

    // ---------------- FIFO / SDRAM stand-in ----------------
    logic [DW-1:0] mem_q[$];
    logic [NW-1:0] fill = '0;
    logic          hold_en = 1'b0;
    logic [NW-1:0] hold_num = '0;
    int unsigned   rd_cnt = 0;

    assign fif.rd_fifo_num = hold_en ? hold_num : fill;

    always @(posedge clk) begin
        logic [DW-1:0] w;
        if (rst) begin
            mem_q.delete();
            fill                <= '0;
            fif.rd_fifo_rd_data <= '0;
        end else begin
            if (start) rd_cnt = 0;
            if (fif.wr_fifo_wr_req) mem_q.push_back(fif.wr_fifo_wr_data);
            if (fif.rd_fifo_rd_req) begin
                w = (mem_q.size() > 0) ? mem_q.pop_front() : '0;
                fif.rd_fifo_rd_data <= apply_fault(w, rd_cnt);
                rd_cnt++;
            end
            fill <= NW'(mem_q.size());
        end
    end

    // ---------------- monitor ----------------
    int unsigned cyc = 0, start_cyc = 0, last_wr_cyc = 0, wait_cyc = 0;
    int unsigned pass_wr_cnt = 0, rd_req_seen = 0, done_cnt = 0;
    logic        prev_rd_valid = 1'b1, prev_tmo = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [DW-1:0] ew;
        res_t          r;
        if (!rst) begin
            if (fif.wr_fifo_wr_req) begin
                if (exp_wr_q.size() == 0) flag("unexpected_write");
                else begin
                    ew = exp_wr_q.pop_front();
                    check("wr_data", fif.wr_fifo_wr_data, ew);
                end
                if (pass_wr_cnt == 0) check("first_wr_offset", cyc - start_cyc, GAP);
                else                  check("wr_spacing", cyc - last_wr_cyc, GAP + 1);
                last_wr_cyc = cyc;
                pass_wr_cnt++;
            end
            if (fif.rd_fifo_rd_req) rd_req_seen++;
            if (prev_rd_valid && !fif.rd_valid) wait_cyc = cyc;
            if (timeout && !prev_tmo) check("timeout_latency", cyc - wait_cyc, TO);
            if (done) begin
                done_cnt++;
                if (exp_res_q.size() == 0) flag("unexpected_done");
                else begin
                    r = exp_res_q.pop_front();
                    check("pass", pass, r.pass);
                    check("timeout", timeout, r.tmo);
                    check("err_cnt", err_cnt, r.err);
                    check("first_err_idx", first_err_idx, r.first);
                end
            end
        end
        prev_rd_valid = fif.rd_valid;
        prev_tmo      = timeout;
    end

    // ---------------- stimulus ----------------
    task automatic launch(input logic [1:0] m, input bit tmo);
        int unsigned   errs;
        logic [NW-1:0] first;
        logic [DW-1:0] w;
        res_t          r;
        errs  = 0;
        first = '1;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            w = pattern(m, i);
            exp_wr_q.push_back(w);
            if (!tmo && apply_fault(w, i) != w) begin
                errs++;
                if (first == '1) first = NW'(i);
            end
        end
        r.tmo   = tmo;
        r.err   = NW'(errs);
        r.first = first;
        r.pass  = !tmo && (errs == 0);
        exp_res_q.push_back(r);
        @(negedge clk);
        mode        = m;
        start       = 1'b1;
        start_cyc   = cyc + 1;
        pass_wr_cnt = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned n0, k;
        n0 = done_cnt;
        k  = 0;
        while (done_cnt == n0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_in_budget", done_cnt != n0, 1'b1);
    endtask

    task automatic set_fault(input int kind, input int unsigned idx, input logic [DW-1:0] x);
        fault_kind = kind;
        fault_idx  = idx;
        fault_xor  = x;
    endtask

    initial begin
        int unsigned k;
        logic [1:0]  m;
        rst = 1'b1; start = 1'b0; start_b = 1'b0; mode = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_err_idx", first_err_idx, 10'h3FF);
        check("rst_rd_valid", fif.rd_valid, 1'b1);
        check("rst_wr_req", fif.wr_fifo_wr_req, 1'b0);
        check("rst_rd_req", fif.rd_fifo_rd_req, 1'b0);
        check("rst_b_first_err_idx", first_b, 3'h7);
        rst = 1'b0;

        set_fault(F_NONE, 0, '0);
        launch(2'd0, 1'b0); wait_done(400);
        launch(2'd1, 1'b0); wait_done(400);
        set_fault(F_BIT0, 4, '0);
        launch(2'd1, 1'b0); wait_done(400);

        // Start pulsed mid-write must not add words or restart the pass.
        set_fault(F_NONE, 0, '0);
        launch(2'd0, 1'b0);
        repeat (20) @(negedge clk);
        start = 1'b1; mode = 2'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);
        check("writes_per_pass", pass_wr_cnt, NWORDS);
        launch(2'd3, 1'b0); wait_done(400);

        set_fault(F_ZERO, 0, '0);
        launch(2'd0, 1'b0); wait_done(400);

        for (int unsigned p = 0; p < 8; p++) begin
            m = 2'($urandom_range(0, 3));
            set_fault(int'($urandom_range(0, 3)), $urandom_range(0, NWORDS - 1),
                      DW'($urandom_range(1, 16'hFFFF)));
            launch(m, 1'b0); wait_done(400);
        end

        // Abort at word 5 of the read phase, with start asserted alongside rst.
        set_fault(F_NONE, 0, '0);
        launch(2'd2, 1'b0);
        k = 0;
        while (!fif.rd_fifo_rd_req && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("reached_read", fif.rd_fifo_rd_req, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        exp_res_q.delete();
        exp_wr_q.delete();
        check("abort_rd_req", fif.rd_fifo_rd_req, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_rd_valid", fif.rd_valid, 1'b1);
        check("abort_err_cnt", err_cnt, 0);
        check("abort_first_err_idx", first_err_idx, 10'h3FF);
        @(negedge clk);
        check("rst_beats_start", busy, 1'b0);
        launch(2'd1, 1'b0); wait_done(400);

        // Read FIFO never reaches NUM_WORDS.
        hold_en = 1'b1; hold_num = NW'(NWORDS - 1);
        launch(2'd0, 1'b0);
        rd_req_seen = 0;
        exp_res_q.delete();
        exp_res_q.push_back('{pass: 1'b0, tmo: 1'b1, err: '0, first: '1});
        wait_done(600);
        check("timeout_no_rd_req", rd_req_seen, 0);
        @(negedge clk);
        check("timeout_sticky", timeout, 1'b1);
        check("timeout_no_pass", pass, 1'b0);
        hold_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Narrow instance: every word mismatches, err_cnt lands on all-ones without wrapping.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = 0;
        while (!done_b && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("b_done_in_budget", done_b, 1'b1);
        check("b_err_cnt", err_b, 3'd7);
        check("b_first_err_idx", first_b, 3'd0);
        check("b_pass", pass_b, 1'b0);
        check("b_timeout", timeout_b, 1'b0);
        repeat (3) @(negedge clk);
        check("b_err_hold", err_b, 3'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
